instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch/sequencer stage directly upstream of the processor core. It holds a small loadable program memory and a program counter. It presents one 16-bit instruction at a time on `instruction` with `run` asserted, waits for the core's `done`, then advances to the next word. Execution stops on a halt word or at the end of memory.

## Interface
Parameters:
- `DEPTH`, 16: number of 16-bit program words (power of two).
- `ADDR_W`, 4: address width, equal to log2(DEPTH).
- `HALT_WORD`, 16'h0000: instruction encoding that stops fetching. It is never issued to the core.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `load_en` input 1: write `load_data` into `mem[load_addr]`.
- `load_addr` input ADDR_W: program load address.
- `load_data` input 16: program load word.
- `start` input 1: begin execution from address 0.
- `core_done` input 1: core has completed the current instruction (core `done`).
- `instruction` output 16: instruction to core, registered.
- `run` output 1: instruction valid; core may execute.
- `pc` output ADDR_W: address of the current/next instruction.
- `busy` output 1: high in FETCH, ISSUE, WAIT and ADVANCE.
- `halted` output 1: program finished; held until `start` or reset.

## Operation
- Memory is DEPTH×16, written synchronously and read synchronously. It is not cleared by reset.
- Loads are accepted only in IDLE or HALTED. A `load_en` in any other state is ignored (no write).
- FSM states: IDLE, FETCH, ISSUE, WAIT, ADVANCE, HALTED.
- IDLE / HALTED + `start` → FETCH. On the same edge, `pc`←0 and `halted`←0.
- FETCH: read `mem[pc]`, then go to ISSUE.
- ISSUE:
  - If the fetched word == HALT_WORD: go to HALTED with `halted`←1. `run` stays 0 and `instruction` is unchanged.
  - Otherwise: `instruction`←word, `run`←1, go to WAIT.
- WAIT: hold `instruction` and `run` stable. When `core_done`=1 is sampled: `run`←0 and go to ADVANCE.
- ADVANCE:
  - If `pc`==DEPTH-1: go to HALTED with `halted`←1. There is no wrap.
  - Otherwise: `pc`←`pc`+1 and go to FETCH.
- `start` is ignored while `busy`=1.
- `core_done` is ignored outside WAIT.
- Same-cycle `load_en` and `start` in IDLE/HALTED: both are accepted. The write lands before FETCH reads, so a write to address 0 is the first word fetched.

## Timing
- Reset values: `instruction`=0, `run`=0, `pc`=0, `busy`=0, `halted`=0, state=IDLE. All are asynchronous.
- Reset asserted mid-execution: `run` drops in the same instant and the FSM returns to IDLE. Memory contents are retained.
- `start` sampled at edge N:
  - `busy`=1 after edge N.
  - `instruction` and `run`=1 are valid after edge N+2 (FETCH at N+1, ISSUE at N+2).
- `core_done` sampled at edge M:
  - `run`=0 after M.
  - `pc` increments after M+1.
  - Next `run`=1 after M+3.
- Minimum issue-to-issue spacing is 4 cycles plus the core latency.
- `run` is never high during FETCH, ADVANCE, IDLE or HALTED.
- `instruction` changes only in ISSUE. It keeps its last value otherwise, including after HALTED.
- `core_done` held high continuously: each WAIT still consumes exactly one instruction. There is no double advance.

## Test plan
- **Reset:** drive `reset`=1 mid-WAIT → `run`=0, `busy`=0, `pc`=0 immediately. Then `start` with the same program → `instruction`=mem[0] and `run`=1 three edges after `start`.
- **Linear program:** load 0x2104, 0x4A09, 0x0000 at addresses 0–2, then pulse `start`. The core model asserts `core_done` 2 cycles after `run`. → Issued sequence is exactly 0x2104, then 0x4A09. Then `halted`=1, `run`=0, `pc`=2.
- **End of memory:** fill all 16 words with 0x0101 and run. → 16 issues, `pc`=15, then `halted`=1 with no wrap to 0.
- **Load protection:** `load_en` to addr 1 while in WAIT → the read-back run issues the original mem[1]. The same load in HALTED → the new value is issued on restart.
- **Handshake stall:** hold `core_done`=0 for 20 cycles → `instruction` and `run` stay constant. Raise `core_done` for 1 cycle → exactly one advance. Hold `core_done`=1 continuously → one advance per WAIT.
- **Simultaneous:** `load_en`(addr 0, 0xBEEF) and `start` on the same edge from IDLE → the first issued instruction is 0xBEEF.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: loadable program memory plus a PC that issues one
// word at a time to the core and advances on the core's done handshake.
module instr_fetch #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              start,
    input  logic              core_done,
    output logic [15:0]       instruction,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_HALTED
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       instruction_reg, instruction_next;
    logic              run_reg, run_next;
    logic              halted_reg, halted_next;

    logic [15:0]       mem [DEPTH];
    logic [15:0]       fetch_data_reg;
    logic              load_accept;

    // Program writes are only allowed while nothing is executing, so a write
    // can never collide with the FETCH read of the same word.
    assign load_accept = load_en && ((state_reg == S_IDLE) || (state_reg == S_HALTED));

    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem[load_addr] <= load_data;
        end
        if (state_reg == S_FETCH) begin
            fetch_data_reg <= mem[pc_reg];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            instruction_reg <= '0;
            run_reg         <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instruction_reg <= instruction_next;
            run_reg         <= run_next;
            halted_reg      <= halted_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instruction_next = instruction_reg;
        run_next         = run_reg;
        halted_next      = halted_reg;
        case (state_reg)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_next  = S_FETCH;
                    pc_next     = '0;
                    halted_next = 1'b0;
                end
            end
            S_FETCH: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                // The halt word is consumed here and never reaches the core.
                if (fetch_data_reg == HALT_WORD) begin
                    state_next  = S_HALTED;
                    halted_next = 1'b1;
                end else begin
                    instruction_next = fetch_data_reg;
                    run_next         = 1'b1;
                    state_next       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    run_next   = 1'b0;
                    state_next = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (pc_reg == LAST_ADDR) begin
                    state_next  = S_HALTED;
                    halted_next = 1'b1;
                end else begin
                    pc_next    = pc_reg + ADDR_W'(1);
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign instruction = instruction_reg;
    assign run         = run_reg;
    assign pc          = pc_reg;
    assign halted      = halted_reg;
    assign busy        = (state_reg == S_FETCH) || (state_reg == S_ISSUE) ||
                         (state_reg == S_WAIT)  || (state_reg == S_ADVANCE);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model predicts the issued
// word sequence and final PC; a monitor pops and compares on every new issue.
module tb_instr_fetch;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [15:0] HALT  = 16'h0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic          core_done = 1'b0;
    logic [15:0]   instruction;
    logic          run;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(DEPTH), .ADDR_W(AW), .HALT_WORD(HALT)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .core_done(core_done),
        .instruction(instruction), .run(run), .pc(pc), .busy(busy), .halted(halted)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] prog [DEPTH];
    logic [15:0] exp_q [$];
    int          exp_pc = 0;
    logic [15:0] last_instr = 16'h0;
    int          core_mode = 0;   // 0: pulse done after core_lat cycles, 1: done held high
    int          core_lat = 2;
    int          wait_cnt = 0;
    logic        run_prev = 1'b0;
    logic [15:0] inst_prev = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core model
    always @(negedge clk) begin
        if (core_mode == 1) begin
            core_done = 1'b1;
        end else if (run && !reset) begin
            if (wait_cnt >= core_lat) core_done = 1'b1;
            else begin
                core_done = 1'b0;
                wait_cnt++;
            end
        end else begin
            core_done = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Monitor: one pop per new issue, plus hold-stability while run stays high
    always @(negedge clk) begin
        if (reset) begin
            run_prev = 1'b0;
        end else begin
            if (run && !run_prev) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_issue: got %0h expected no issue", instruction);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("issue", instruction, e);
                    $display("issue %04h expected %04h pc=%0d", instruction, e, pc);
                end
            end
            if (run && run_prev) chk("hold_instr", instruction, inst_prev);
            if (run) chk("run_implies_busy", busy, 1);
            run_prev  = run;
            inst_prev = instruction;
        end
    end

    // Model: walk from address 0 until the halt word or the end of memory
    task automatic issue_expect();
        exp_q.delete();
        exp_pc = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            if (model_mem[a] == HALT) begin
                exp_pc = a;
                break;
            end
            exp_q.push_back(model_mem[a]);
            last_instr = model_mem[a];
        end
    endtask

    // All drive tasks start and end at a falling edge
    task automatic load_word(input int a, input logic [15:0] d, input bit accepted);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        if (accepted) model_mem[a] = d;
    endtask

    task automatic load_all();
        for (int a = 0; a < DEPTH; a++) load_word(a, prog[a], 1'b1);
    endtask

    task automatic do_start(input bit with_load, input int la, input logic [15:0] ld,
                            input bit check_timing);
        start = 1'b1;
        if (with_load) begin
            load_en = 1'b1;
            load_addr = AW'(la);
            load_data = ld;
            model_mem[la] = ld;
        end
        issue_expect();
        @(negedge clk);
        start = 1'b0;
        load_en = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("halted_cleared", halted, 0);
        if (check_timing) begin
            chk("run_edge_n", run, 0);
            @(negedge clk);
            chk("run_edge_n1", run, 0);
            @(negedge clk);
            chk("run_edge_n2", run, (model_mem[0] != HALT) ? 1 : 0);
            if (model_mem[0] != HALT) chk("instr_edge_n2", instruction, model_mem[0]);
        end
    endtask

    task automatic wait_run();
        int i;
        for (i = 0; i < 200; i++) begin
            if (run) break;
            @(negedge clk);
        end
        if (i == 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_run: got timeout expected run=1");
        end
    endtask

    task automatic wait_halt();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (halted) break;
            @(negedge clk);
        end
        if (i == 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_halt: got timeout expected halted=1");
        end
        chk("halt_pc", pc, exp_pc);
        chk("halt_run", run, 0);
        chk("halt_busy", busy, 0);
        chk("halt_pending", exp_q.size(), 0);
        chk("halt_instr_kept", instruction, last_instr);
        $display("halted pc=%0d expected %0d", pc, exp_pc);
    endtask

    initial begin
        reset = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_instr", instruction, 0);
        chk("rst_run", run, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b0;
        @(negedge clk);

        // Linear program with start-latency check
        for (int a = 0; a < DEPTH; a++) prog[a] = 16'h1000 + 16'(a);
        prog[0] = 16'h2104; prog[1] = 16'h4A09; prog[2] = HALT;
        load_all();
        core_mode = 0; core_lat = 2;
        do_start(1'b0, 0, 16'h0, 1'b1);
        wait_halt();

        // Reset asserted mid-WAIT, then restart the same program
        core_lat = 50;
        do_start(1'b0, 0, 16'h0, 1'b0);
        wait_run();
        #2 reset = 1'b1;
        #1;
        chk("midrst_run", run, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_instr", instruction, 0);
        exp_q.delete();
        last_instr = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        core_lat = 2;
        do_start(1'b0, 0, 16'h0, 1'b1);
        wait_halt();

        // Simultaneous load and start from IDLE
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_instr = 16'h0;
        @(negedge clk);
        do_start(1'b1, 0, 16'hBEEF, 1'b1);
        wait_halt();

        // End of memory with core_done held high
        for (int a = 0; a < DEPTH; a++) prog[a] = 16'h0101;
        load_all();
        core_mode = 1;
        do_start(1'b0, 0, 16'h0, 1'b0);
        wait_halt();
        core_mode = 0;
        @(negedge clk);

        // Load protection: ignored in WAIT, accepted in HALTED
        for (int a = 0; a < DEPTH; a++) prog[a] = 16'h5000 + 16'(a);
        prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = HALT;
        load_all();
        core_lat = 3;
        do_start(1'b0, 0, 16'h0, 1'b0);
        wait_run();
        load_word(1, 16'h7777, 1'b0);
        wait_halt();
        load_word(1, 16'h7777, 1'b1);
        do_start(1'b0, 0, 16'h0, 1'b0);
        wait_halt();

        // Handshake stall: long core latency, monitor checks stability
        prog[0] = 16'h3333; prog[1] = 16'h4444; prog[2] = HALT;
        load_all();
        core_lat = 20;
        do_start(1'b0, 0, 16'h0, 1'b0);
        wait_halt();

        // Randomized programs and core behaviour
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < DEPTH; a++)
                prog[a] = ($urandom_range(0, 7) == 0) ? HALT : 16'($urandom_range(1, 16'hFFFF));
            load_all();
            core_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            core_lat  = $urandom_range(0, 4);
            do_start(1'b0, 0, 16'h0, (it % 3) == 0);
            if (model_mem[0] != HALT && ($urandom_range(0, 1) == 1)) begin
                wait_run();
                load_word($urandom_range(0, DEPTH - 1), 16'($urandom), 1'b0);
            end
            wait_halt();
            core_mode = 0;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
